traffic_countdown: RTL

TRAFFIC_COUNTDOWN -- requirements
Module: traffic_countdown

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/btn_debounce.sv | 58 +++++
 rtl/traffic_countdown.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic countdown: phase and debounce encodings,
// light one-hots, the seven-segment table and a constant BCD helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        DB_ARMED     = 2'd0,
        DB_FIRE      = 2'd1,
        DB_WAIT_HIGH = 2'd2
    } db_state_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam logic [6:0] SEG_BLANK = 7'h7f;

    // Active-low {g..a}, indexed by BCD digit value.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        seg_of = (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;
    endfunction

    // Elaboration-time only: turns a period parameter into four BCD digits.
    function automatic logic [15:0] to_bcd(input int value);
        int v;
        v = value;
        to_bcd = '0;
        for (int i = 0; i < 4; i++) begin
            to_bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button debouncer: one press pulse after DB_CYCLES low samples,
// re-armed only after DB_CYCLES consecutive high samples.
module btn_debounce import traffic_pkg::*; #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    db_state_t     state;
    db_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          cnt_hit;

    assign cnt_hit = (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DB_ARMED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // cnt counts consecutive samples of the level that moves the FSM on.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            DB_ARMED: begin
                if (!btn_n) begin
                    if (cnt_hit) state_nx = DB_FIRE;
                    else         cnt_nx   = cnt + 1'b1;
                end
            end
            DB_FIRE, DB_WAIT_HIGH: begin
                state_nx = DB_WAIT_HIGH;
                if (btn_n) begin
                    if (cnt_hit) state_nx = DB_ARMED;
                    else         cnt_nx   = cnt + 1'b1;
                end
            end
            default: state_nx = DB_ARMED;
        endcase
    end

    always_comb begin
        press = (state == DB_FIRE);
    end

endmodule

// File: rtl/traffic_countdown.sv
// Traffic light controller with a BCD seconds countdown, pause, debounced
// +/- adjust buttons and a registered seven-segment display.
module traffic_countdown import traffic_pkg::*; #(
    parameter int NUM_DIGITS = 2,
    parameter int GREEN_SEC  = 20,
    parameter int YELLOW_SEC = 3,
    parameter int RED_SEC    = 20,
    parameter int TICK_DIV   = 16000000,
    parameter int DB_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause,
    input  logic                    count_up_n,
    input  logic                    count_dn_n,
    output logic [2:0]              light,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    phase_done
);

    localparam int CNT_W = 4 * NUM_DIGITS;
    localparam int TW    = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] GREEN_BCD  = CNT_W'(to_bcd(GREEN_SEC));
    localparam logic [CNT_W-1:0] YELLOW_BCD = CNT_W'(to_bcd(YELLOW_SEC));
    localparam logic [CNT_W-1:0] RED_BCD    = CNT_W'(to_bcd(RED_SEC));

    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    logic                    up_pulse;
    logic                    dn_pulse;
    logic                    adjust;
    logic                    advance;
    logic                    count_is_one;
    logic                    count_is_max;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_inc;
    logic [CNT_W-1:0]        count_dec;
    logic [CNT_W-1:0]        count_nx;
    logic [CNT_W-1:0]        period_nx;
    logic [7*NUM_DIGITS-1:0] hex_nx;
    phase_t                  phase;
    phase_t                  phase_nx;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn_n (count_up_n),
        .press (up_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (count_dn_n),
        .press (dn_pulse)
    );

    assign tick    = !pause && (tick_cnt == TW'(TICK_DIV - 1));
    assign adjust  = up_pulse ^ dn_pulse;
    assign advance = tick && !adjust && count_is_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!pause) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Digit-serial BCD increment/decrement; a carry out of the top digit
    // means every digit was 9, which is the saturation point.
    always_comb begin
        logic [3:0] digit;
        logic       carry;
        logic       borrow;
        digit        = '0;
        carry        = 1'b1;
        borrow       = 1'b1;
        count_inc    = count;
        count_dec    = count;
        count_is_one = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
            count_is_one = count_is_one && (digit == ((i == 0) ? 4'd1 : 4'd0));
        end
        count_is_max = carry;
    end

    always_comb begin
        case (phase)
            GREEN:   period_nx = YELLOW_BCD;
            YELLOW:  period_nx = RED_BCD;
            default: period_nx = GREEN_BCD;
        endcase
    end

    // Button adjustments win over the tick; simultaneous up+down cancel out.
    always_comb begin
        count_nx = count;
        if (up_pulse && !dn_pulse) begin
            if (!count_is_max) count_nx = count_inc;
        end else if (dn_pulse && !up_pulse) begin
            if (!count_is_one) count_nx = count_dec;
        end else if (advance) begin
            count_nx = period_nx;
        end else if (tick) begin
            count_nx = count_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= GREEN_BCD;
            phase_done <= 1'b0;
        end else begin
            count      <= count_nx;
            phase_done <= advance;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) phase <= GREEN;
        else     phase <= phase_nx;
    end

    always_comb begin
        phase_nx = phase;
        if (advance) begin
            case (phase)
                GREEN:   phase_nx = YELLOW;
                YELLOW:  phase_nx = RED;
                default: phase_nx = GREEN;
            endcase
        end
    end

    always_comb begin
        case (phase)
            YELLOW:  light = LIGHT_YELLOW;
            RED:     light = LIGHT_RED;
            default: light = LIGHT_GREEN;
        endcase
    end

    // Walk from the most significant digit; zeros stay blank until the first
    // non-zero digit, and digit 0 is always shown.
    always_comb begin
        logic [3:0] digit;
        logic       lead;
        digit  = '0;
        lead   = 1'b1;
        hex_nx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit = count[4*i +: 4];
            lead  = lead && (digit == 4'd0) && (i != 0);
            hex_nx[7*i +: 7] = lead ? SEG_BLANK : seg_of(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hex <= {NUM_DIGITS{SEG_BLANK}};
        else     hex <= hex_nx;
    end

endmodule
